// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and helpers for the bit-serial subtractor.
//   - state_t : FSM encoding (IDLE, RUN, DONE), 2 bits.
//   - count_w : width of the bit counter for a given operand width.
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width sized to hold WIDTH itself, so WIDTH=1 still gets one bit
    // and the last-bit compare never relies on wrap-around.
    function automatic int count_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   1-bit full-subtractor cell: a - b - bin.
//   Ports:
//     a, b  : operand bits
//     bin   : borrow in
//     d     : difference bit
//     bout  : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they are equal and a borrow
    // is already pending from the lower bit.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor, diff = a - b (mod 2^WIDTH), LSB first,
//   one bit per clock through a single full_subtractor cell.
//
//   Parameters:
//     WIDTH  : operand/result width, 1..64 (default 8).
//
//   Ports:
//     clk    : clock, rising edge.
//     rst    : asynchronous active-high reset.
//     start  : request, sampled only in IDLE; captures a and b.
//     a, b   : minuend / subtrahend.
//     busy   : high while in RUN.
//     done   : one-cycle strobe, results valid.
//     diff   : a - b modulo 2^WIDTH, held until the next completion.
//     borrow : final borrow-out (a < b unsigned), held likewise.
//     ovf    : signed overflow flag, held likewise.
//
//   Optional feature (macro SERIAL_SUB_SIGNED_OVF_EN):
//     defined   : ovf registered with done from the captured operand MSBs.
//     undefined : ovf tied to 0, no extra flops; port list unchanged.
//
//   Timing: accept at edge T -> done high between edges T+WIDTH and
//   T+WIDTH+1; back-to-back throughput one result every WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = count_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH:0]   res_ext;
    logic             bin;
    logic             d;
    logic             bout;
    logic             last;

    // -------------------------------------------------------------------------
    // Per-bit cell
    // -------------------------------------------------------------------------
    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    assign last = (count == CW'(WIDTH - 1));

    // New difference bit enters at the MSB; building the WIDTH+1 vector and
    // dropping its LSB keeps the shift legal even when WIDTH is 1.
    assign res_ext = {d, res};
    assign res_nxt = res_ext[WIDTH:1];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment on entry covers every path, so no latch
    // is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:               state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from the registered state)
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            bin    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bin   <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    bin   <= bout;
                    res   <= res_nxt;
                    count <= count + CW'(1);
                    if (last) begin
                        diff   <= res_nxt;
                        borrow <= bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // Operand MSBs are kept separately because a_sh/b_sh are shifted out by
    // the time the result is complete.
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == RUN && last) begin
                ovf <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
            end
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
